// File: rtl/lcd_byte_writer.sv
// Byte writer for an HD44780-style LCD.
// Each request drives RS/DATA, strobes E, then waits a number of timer ticks before the next byte.
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned E_HIGH_CYC  = 12,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned SHORT_TICKS = 2,
  parameter int unsigned LONG_TICKS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_long,
  input  logic [7:0] req_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] E_HIGH_LAST = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] phase_cnt_q, phase_cnt_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic       long_q, long_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_e_q, lcd_e_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       done_q, done_d;
  logic [3:0] tick_target;
  logic       accept;

  assign accept      = req_valid && (state_q == S_IDLE);
  assign tick_target = long_q ? 4'(LONG_TICKS) : 4'(SHORT_TICKS);

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    long_d      = long_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_SETUP;
          phase_cnt_d = 8'd0;
          tick_cnt_d  = 4'd0;
          long_d      = req_long;
          lcd_rs_d    = req_rs;
          lcd_data_d  = req_data;
        end
      end
      S_SETUP: begin
        if (phase_cnt_q == SETUP_LAST) begin
          state_d     = S_PULSE;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      S_PULSE: begin
        if (phase_cnt_q == E_HIGH_LAST) begin
          state_d     = S_HOLD;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (phase_cnt_q == HOLD_LAST) begin
          state_d     = S_WAIT;
          phase_cnt_d = 8'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        // Only ticks seen here count; the first may land in the very first WAIT cycle.
        if (tick) begin
          if ((tick_cnt_q + 4'd1) == tick_target) begin
            state_d    = S_IDLE;
            tick_cnt_d = 4'd0;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // E is registered off the next state so it is high exactly while in PULSE.
    lcd_e_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= 8'd0;
      tick_cnt_q  <= 4'd0;
      long_q      <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_data_q  <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      long_q      <= long_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      lcd_data_q  <= lcd_data_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer: table of single writes plus back-to-back and mid-pulse reset sequences.
// Cycle k=0 is the accept cycle; with default parameters E is high in k=5..16 and WAIT begins at k=21.
module tb_lcd_byte_writer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic       req_long;
  logic [7:0] req_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       busy;
  logic       done;

  localparam int E_RISE_K   = 5;
  localparam int E_LEN      = 12;
  localparam int WAIT_START = 21;

  lcd_byte_writer dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_long  (req_long),
    .req_data  (req_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       lng;
    logic [7:0] data;
    bit         pre;      // tick high every cycle from accept through HOLD
    int         period;   // WAIT-phase tick period
    int         offset;   // first WAIT tick at WAIT_START + offset
    int         exp_done; // expected cycle of the done pulse
  } vec_t;

  vec_t vecs[7];
  int   n_cmp;
  int   n_err;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic run_vector(input vec_t v, input int idx);
    int rise, elen, dk, data_ok, busy_ok, rw_ok, rdy_done;
    rise = -1; elen = 0; dk = -1; data_ok = 1; busy_ok = 1; rw_ok = 1; rdy_done = 0;
    check($sformatf("v%0d ready_before", idx), int'(req_ready), 1);
    req_valid = 1'b1;
    req_rs    = v.rs;
    req_long  = v.lng;
    req_data  = v.data;
    tick      = v.pre;
    for (int k = 1; k <= 400 && dk < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        req_rs    = ~v.rs;
        req_long  = ~v.lng;
        req_data  = ~v.data;
      end
      if (lcd_e) begin
        if (rise < 0) rise = k;
        elen++;
      end
      if (lcd_data !== v.data || lcd_rs !== v.rs) data_ok = 0;
      if (lcd_rw !== 1'b0) rw_ok = 0;
      if (done) begin
        dk = k;
        rdy_done = int'(req_ready && !busy);
      end else if (busy !== 1'b1 || req_ready !== 1'b0) begin
        busy_ok = 0;
      end
      tick = (v.pre && k < WAIT_START) ||
             (k >= WAIT_START && ((k - WAIT_START) % v.period) == v.offset);
    end
    tick = 1'b0;
    check($sformatf("v%0d e_rise_cycle", idx), rise, E_RISE_K);
    check($sformatf("v%0d e_high_len", idx), elen, E_LEN);
    check($sformatf("v%0d rs_data_stable", idx), data_ok, 1);
    check($sformatf("v%0d rw_zero", idx), rw_ok, 1);
    check($sformatf("v%0d busy_while_active", idx), busy_ok, 1);
    check($sformatf("v%0d done_cycle", idx), dk, v.exp_done);
    check($sformatf("v%0d ready_at_done", idx), rdy_done, 1);
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), int'(done), 0);
    check($sformatf("v%0d data_retained", idx), int'(lcd_data), int'(v.data));
  endtask

  initial begin
    int rises, e_cycles, n_done, done1, done2, rise1, rise2, d_rise1, d_rise2, d22, d24, prev_e;

    n_cmp = 0;
    n_err = 0;
    //          rs    long  data   pre period off done
    vecs[0] = '{1'b0, 1'b0, 8'h38, 0, 50, 29, 101};
    vecs[1] = '{1'b0, 1'b1, 8'h01, 0, 10,  0,  42};
    vecs[2] = '{1'b1, 1'b0, 8'hA5, 1,  5,  3,  30};
    vecs[3] = '{1'b1, 1'b0, 8'hA5, 0,  5,  3,  30};
    vecs[4] = '{1'b0, 1'b1, 8'h02, 1,  4,  0,  30};
    vecs[5] = '{1'b1, 1'b0, 8'h7E, 0,  1,  0,  23};
    vecs[6] = '{1'b1, 1'b1, 8'hFF, 1,  2,  1,  27};

    rst = 1'b0; tick = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_long = 1'b0; req_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst lcd_e", int'(lcd_e), 0);
    check("rst lcd_rs", int'(lcd_rs), 0);
    check("rst lcd_data", int'(lcd_data), 0);
    check("rst lcd_rw", int'(lcd_rw), 0);
    check("rst done", int'(done), 0);
    check("rst req_ready", int'(req_ready), 1);
    check("rst busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vector(vecs[i], i);
    end

    // Back-to-back: valid held high, second byte presented while busy.
    rises = 0; e_cycles = 0; n_done = 0; done1 = -1; done2 = -1;
    rise1 = -1; rise2 = -1; d_rise1 = -1; d_rise2 = -1; d22 = -1; d24 = -1; prev_e = 0;
    req_valid = 1'b1; req_rs = 1'b1; req_long = 1'b0; req_data = 8'h41; tick = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) req_data = 8'h42;
      if (k == 24) req_valid = 1'b0;
      if (lcd_e) e_cycles++;
      if (lcd_e && !prev_e) begin
        rises++;
        if (rises == 1) begin rise1 = k; d_rise1 = int'(lcd_data); end
        if (rises == 2) begin rise2 = k; d_rise2 = int'(lcd_data); end
      end
      prev_e = int'(lcd_e);
      if (done) begin
        n_done++;
        if (n_done == 1) done1 = k;
        if (n_done == 2) done2 = k;
      end
      if (k == 22) d22 = int'(lcd_data);
      if (k == 24) d24 = int'(lcd_data);
    end
    tick = 1'b0;
    check("b2b e_pulses", rises, 2);
    check("b2b e_cycles", e_cycles, 2 * E_LEN);
    check("b2b rise1_cycle", rise1, 5);
    check("b2b rise1_data", d_rise1, 8'h41);
    check("b2b rise2_cycle", rise2, 28);
    check("b2b rise2_data", d_rise2, 8'h42);
    check("b2b done_count", n_done, 2);
    check("b2b done1_cycle", done1, 23);
    check("b2b done2_cycle", done2, 46);
    check("b2b data_kept_while_busy", d22, 8'h41);
    check("b2b data_after_accept", d24, 8'h42);

    // Reset during the 6th PULSE cycle.
    req_valid = 1'b1; req_rs = 1'b1; req_long = 1'b0; req_data = 8'h5A; tick = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    check("rstmid e_before", int'(lcd_e), 1);
    #1 rst = 1'b0;
    #1;
    check("rstmid e_async", int'(lcd_e), 0);
    check("rstmid lcd_data", int'(lcd_data), 0);
    check("rstmid lcd_rs", int'(lcd_rs), 0);
    check("rstmid done", int'(done), 0);
    check("rstmid req_ready", int'(req_ready), 1);
    check("rstmid busy", int'(busy), 0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    tick = 1'b0;
    rst = 1'b1;
    run_vector(vecs[5], 7);
    check("rstmid no_stale_done", n_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 4: clk cycles that RS/DATA are stable before E rises (legal range 1..255).
REQ-002 The block SHALL have parameter E_HIGH_CYC, default 12: clk cycles E is held high (legal range 1..255).
REQ-003 The block SHALL have parameter HOLD_CYC, default 4: clk cycles that RS/DATA are held after E falls (legal range 1..255).
REQ-004 The block SHALL have parameter SHORT_TICKS, default 2: tick pulses to wait after a normal byte (legal range 1..15).
REQ-005 The block SHALL have parameter LONG_TICKS, default 3: tick pulses to wait after a long command such as clear or home (legal range 1..15).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port tick, input, 1 bit: one-clk-wide timebase pulse from the ms timer chain.
REQ-009 The block SHALL have port req_valid, input, 1 bit: a write request is present.
REQ-010 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-011 The block SHALL have port req_rs, input, 1 bit: register select, 0 = command, 1 = data.
REQ-012 The block SHALL have port req_long, input, 1 bit: use LONG_TICKS instead of SHORT_TICKS.
REQ-013 The block SHALL have port req_data, input, 8 bits: the byte to write.
REQ-014 The block SHALL have port lcd_rs, output, 1 bit: LCD RS pin.
REQ-015 The block SHALL have port lcd_rw, output, 1 bit: LCD RW pin, constant 0 because the block only writes.
REQ-016 The block SHALL have port lcd_e, output, 1 bit: LCD enable strobe.
REQ-017 The block SHALL have port lcd_data, output, 8 bits: LCD DB7..DB0.
REQ-018 The block SHALL have port busy, output, 1 bit: equal to the inverse of req_ready.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a write.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD and WAIT; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted in any cycle where req_valid=1 and req_ready=1; req_rs, req_long and req_data SHALL be latched in that cycle.
REQ-022 Request inputs SHALL be ignored outside the accept cycle.
REQ-023 After an accept in cycle T, the FSM SHALL be in SETUP from T+1 with lcd_rs and lcd_data driven from the latched values and lcd_e=0.
REQ-024 SETUP SHALL last exactly SETUP_CYC cycles, then PULSE.
REQ-025 PULSE SHALL hold lcd_e=1 for exactly E_HIGH_CYC cycles, then HOLD.
REQ-026 HOLD SHALL hold lcd_e=0 with lcd_rs and lcd_data unchanged for exactly HOLD_CYC cycles, then WAIT.
REQ-027 WAIT SHALL count tick pulses sampled while in WAIT, with a target of LONG_TICKS if the latched req_long=1 and SHORT_TICKS otherwise.
REQ-028 Ticks arriving in IDLE, SETUP, PULSE or HOLD SHALL NOT be counted.
REQ-029 Because the first tick can arrive in the first WAIT cycle, the guaranteed minimum wait SHALL be (target-1) ms.
REQ-030 In the cycle after the final counted tick, the FSM SHALL be in IDLE with done=1 for exactly that one cycle and req_ready=1.
REQ-031 A request presented in the done cycle SHALL be accepted, giving back-to-back writes with zero idle gap.
REQ-032 lcd_rs and lcd_data SHALL retain the last written values in IDLE.
REQ-033 lcd_rw SHALL be 0 at all times.
REQ-034 lcd_rs, lcd_e, lcd_data and done SHALL be driven from registers, with no combinational path from request inputs.
REQ-035 Phase counters SHALL be 8 bits and the tick counter 4 bits; no counter SHALL wrap within a legal parameter range.
REQ-036 A write with strobe and wait complete SHALL take 1 + SETUP_CYC + E_HIGH_CYC + HOLD_CYC cycles plus the WAIT duration from accept to done.

Reset
REQ-037 While rst=0, asynchronously: state=IDLE; lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, done=0; all counters 0; req_ready=1 and busy=0.
REQ-038 Reset asserted mid-write (including during PULSE) SHALL drop lcd_e to 0 immediately without waiting for a clock edge.
REQ-039 Reset SHALL discard the in-flight request, and no done pulse SHALL follow.
REQ-040 After rst rises, the first accept SHALL be possible on the first clk edge.

Verification
REQ-041 Use default parameters, request rs=0, data=8'h38, long=0, and ticks every 50 cycles: lcd_e is high for exactly 12 cycles starting 5 cycles after the accept, lcd_data=8'h38 throughout, and done occurs after exactly 2 ticks counted in WAIT.
REQ-042 Request data=8'h01 with long=1 and a tick coincident with the first WAIT cycle: that tick is counted, and done occurs in the cycle after the 3rd tick.
REQ-043 Inject ticks during SETUP, PULSE and HOLD: none are counted, and the WAIT length is unchanged versus the tick-free case.
REQ-044 Hold req_valid high with bytes 8'h41 then 8'h42: the second byte is accepted in the done cycle of the first, and the E pulses are correctly ordered with no lost or duplicated byte.
REQ-045 Pull rst low in the 6th PULSE cycle: lcd_e falls to 0 asynchronously, all outputs take their reset values, no done pulse occurs, and a new request after reset completes normally.
REQ-046 Hold req_valid=1 while busy and change req_data: lcd_data keeps the originally accepted byte until the next accept.
